// File: rtl/fp_mul_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_normalize
//  Description : Post-multiply normalise / round / pack stage for the small
//                floating-point multiplier. Takes the 12-bit significand
//                product plus operand signs and biased exponents, and emits
//                {sign, exp, frac[4:0]} with overflow/underflow flags through
//                a valid/ready handshake. One operation in flight at a time.
//                Optional feature macro: FPM_ROUND_NEAREST_EN selects
//                round-to-nearest-even (truncation when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_normalize #(
    parameter int EXP_W = 5,
    parameter int BIAS  = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [11:0]        product,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+5:0]   result,
    output logic               overflow,
    output logic               underflow
);

    // Internal exponent is signed with two headroom bits so that sums of two
    // biased exponents and the rounding carry never wrap.
    localparam int c_EW = EXP_W + 2;
    localparam logic signed [c_EW-1:0] c_BIAS_E = c_EW'(BIAS);
    localparam logic signed [c_EW-1:0] c_EMAX   = c_EW'((1 << EXP_W) - 1);
    localparam logic signed [c_EW-1:0] c_ONE    = c_EW'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_NORM  = 3'd1;
    localparam logic [2:0] c_ROUND = 3'd2;
    localparam logic [2:0] c_PACK  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;

    logic                    r_sign;
    logic                    r_zero;
    logic [EXP_W-1:0]        r_exp_a;
    logic [EXP_W-1:0]        r_exp_b;
    logic [11:0]             r_product;
    logic signed [c_EW-1:0]  r_e;
    logic [5:0]              r_mant;
    logic [EXP_W+5:0]        r_result;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    r_out_valid;

    logic signed [c_EW-1:0]  w_e_base;

`ifdef FPM_ROUND_NEAREST_EN
    logic                    r_guard;
    logic                    r_sticky;
    logic [6:0]              w_mant_inc;
    logic                    w_round_up;

    // Round-to-nearest-even decision and the 7-bit increment (bit 6 = carry).
    assign w_mant_inc = {1'b0, r_mant} + 7'd1;
    assign w_round_up = r_guard & (r_sticky | r_mant[0]);
`endif

    // Unbiased-sum exponent before the normalisation shift adjustment.
    assign w_e_base = $signed({2'b00, r_exp_a}) + $signed({2'b00, r_exp_b}) - c_BIAS_E;

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing: fixed three-step pipeline, then wait for consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_state_nxt = c_NORM;
            c_NORM:  w_state_nxt = c_ROUND;
            c_ROUND: w_state_nxt = c_PACK;
            c_PACK:  w_state_nxt = c_DONE;
            c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: capture, normalise, round, pack and hold the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_product   <= '0;
            r_e         <= '0;
            r_mant      <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef FPM_ROUND_NEAREST_EN
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sign    <= sign_a ^ sign_b;
                        r_zero    <= (exp_a == '0) | (exp_b == '0);
                        r_exp_a   <= exp_a;
                        r_exp_b   <= exp_b;
                        r_product <= product;
                    end
                end
                c_NORM: begin
                    // Product lies in [1,4): a set MSB means shift right by one.
                    if (r_product[11]) begin
                        r_mant <= r_product[11:6];
                        r_e    <= w_e_base + c_ONE;
`ifdef FPM_ROUND_NEAREST_EN
                        r_guard  <= r_product[5];
                        r_sticky <= |r_product[4:0];
`endif
                    end else begin
                        r_mant <= r_product[10:5];
                        r_e    <= w_e_base;
`ifdef FPM_ROUND_NEAREST_EN
                        r_guard  <= r_product[4];
                        r_sticky <= |r_product[3:0];
`endif
                    end
                end
                c_ROUND: begin
`ifdef FPM_ROUND_NEAREST_EN
                    if (w_round_up) begin
                        // Carry out of the mantissa renormalises to 1.00000.
                        if (w_mant_inc[6]) begin
                            r_mant <= 6'b100000;
                            r_e    <= r_e + c_ONE;
                        end else begin
                            r_mant <= w_mant_inc[5:0];
                        end
                    end
`endif
                end
                c_PACK: begin
                    r_out_valid <= 1'b1;
                    if (r_zero) begin
                        r_result    <= {r_sign, {(EXP_W+5){1'b0}}};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end else if (r_e >= c_EMAX) begin
                        r_result    <= {r_sign, {EXP_W{1'b1}}, 5'b00000};
                        r_overflow  <= 1'b1;
                        r_underflow <= 1'b0;
                    end else if (r_e[c_EW-1] || (r_e == '0)) begin
                        r_result    <= {r_sign, {(EXP_W+5){1'b0}}};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b1;
                    end else begin
                        r_result    <= {r_sign, r_e[EXP_W-1:0], r_mant[4:0]};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end
                end
                c_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mul_normalize
//  Description : Self-checking bench for fp_mul_normalize (EXP_W=5, BIAS=15).
//                Vector table plus scoreboard queue, with hand-written
//                backpressure, early-ready and mid-operation reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_normalize;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] product;
    logic        sign_a;
    logic        sign_b;
    logic [4:0]  exp_a;
    logic [4:0]  exp_b;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] result;
    logic        overflow;
    logic        underflow;

    fp_mul_normalize #(.EXP_W(5), .BIAS(15)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sa;
        logic        sb;
        logic [4:0]  ea;
        logic [4:0]  eb;
        logic [11:0] prod;
        logic [10:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic [10:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

`ifdef FPM_ROUND_NEAREST_EN
    localparam logic [10:0] c_R1369 = 11'h1EB;
    localparam logic [10:0] c_RCARRY = 11'h220;
    localparam logic [10:0] c_RTIEODD = 11'h1E2;
`else
    localparam logic [10:0] c_R1369 = 11'h1EA;
    localparam logic [10:0] c_RCARRY = 11'h21F;
    localparam logic [10:0] c_RTIEODD = 11'h1E1;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Run one operation; early_rdy holds out_ready high before out_valid.
    task automatic do_op(input string nm, input vec_t v, input bit early_rdy);
        int   cyc;
        exp_t e;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        sign_a    = v.sa;
        sign_b    = v.sb;
        exp_a     = v.ea;
        exp_b     = v.eb;
        product   = v.prod;
        in_valid  = 1'b1;
        out_ready = early_rdy;
        @(posedge clk);
        sb_q.push_back('{res: v.res, ovf: v.ovf, unf: v.unf});
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_busy"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, 32'(cyc), 32'd3);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL %s_scoreboard actual=empty required=entry", nm);
            end else begin
                e = sb_q.pop_front();
                check({nm, "_result"}, 32'(result), 32'(e.res));
                check({nm, "_flags"}, {30'd0, overflow, underflow}, {30'd0, e.ovf, e.unf});
            end
        end
        if (!early_rdy) begin
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({nm, "_ov_clr"}, 32'(out_valid), 32'd0);
        check({nm, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t one;
        logic [10:0] held;
        vecs[0]  = '{1'b0, 1'b0, 5'd15, 5'd15, 12'h400, 11'h1E0,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'd15, 5'd15, 12'h900, 11'h604,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'd15, 5'd15, 12'h559, c_R1369,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'd15, 5'd15, 12'hFE0, c_RCARRY, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd30, 5'd30, 12'h400, 11'h3E0,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 5'd1,  5'd1,  12'h400, 11'h000,  1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  5'd15, 12'h400, 11'h000,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd15, 5'd0,  12'hFFF, 11'h400,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd23, 5'd23, 12'h400, 11'h3E0,  1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'd15, 5'd30, 12'h400, 11'h3C0,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd15, 5'd30, 12'h800, 11'h3E0,  1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd7,  5'd8,  12'h400, 11'h000,  1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 5'd8,  5'd8,  12'h400, 11'h020,  1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 5'd30, 5'd30, 12'h400, 11'h7E0,  1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 5'd15, 5'd15, 12'h410, 11'h1E0,  1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 5'd15, 5'd15, 12'h430, c_RTIEODD, 1'b0, 1'b0};
        one = vecs[0];

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        product = '0; sign_a = 1'b0; sign_b = 1'b0; exp_a = '0; exp_b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // out_ready high before out_valid: handshake on first valid edge.
        do_op("early_ready", vecs[1], 1'b1);

        // Backpressure: consumer stalls while new requests are offered.
        @(negedge clk);
        sign_a = 1'b0; sign_b = 1'b0; exp_a = 5'd15; exp_b = 5'd15;
        product = 12'h400; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        held = result;
        check("bp_first", 32'(held), 32'h1E0);
        exp_a = 5'd30; exp_b = 5'd30; product = 12'h900; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_result", 32'(result), 32'h1E0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_no_accept", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_ov", 32'(out_valid), 32'd0);

        // Reset while in ROUND aborts the operation without emitting it.
        @(negedge clk);
        exp_a = 5'd15; exp_b = 5'd15; product = 12'h900; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("rstmid_hold_ov", 32'(out_valid), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("rstmid_no_emit", 32'(out_valid), 32'd0);
        do_op("post_reset", one, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
